// File: rtl/serial_arith_pkg.sv
// Shared types and constants for the bit-serial arithmetic units.
package serial_arith_pkg;

  // Operation sequencing: wait for start, shift one bit per cycle, present result.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } ser_state_t;

  // Default operand/result width used when the parameter is not overridden.
  localparam int SER_WIDTH_DEFAULT = 8;

endpackage : serial_arith_pkg

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: computes x - y - bin.
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  logic w_xy_diff;

  // Difference bit and borrow-out of a single subtract step.
  always_comb begin
    w_xy_diff = x ^ y;
    d         = w_xy_diff ^ bin;
    bout      = (~x & y) | (~w_xy_diff & bin);
  end

endmodule : full_subtractor

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: A - B - Bin, LSB first, one bit per
// clock through a single full-subtractor cell and a borrow flip-flop.
//
// Handshake: an operation is accepted on a rising edge where start=1 and
// ready=1 (ready is high only in IDLE). valid is a one-cycle pulse in DONE;
// diff/bout/ovf are registered, change only on entry to DONE, and then hold
// until the next operation completes. start outside IDLE is ignored.
module serial_subtractor
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = SER_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  // Counter only has to reach WIDTH-1; the DONE transition happens there.
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  ser_state_t       r_state;
  ser_state_t       w_next_state;

  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic             r_borrow;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_res;
  logic             r_a_msb;
  logic             r_b_msb;
  logic [WIDTH-1:0] r_diff;
  logic             r_bout;
  logic             r_ovf;

  logic             w_bit;
  logic             w_bit_borrow;
  logic             w_last;
  logic [WIDTH-1:0] w_res_next;

  // The single per-cycle bit cell.
  full_subtractor u_cell (
    .x    (r_a_sh[0]),
    .y    (r_b_sh[0]),
    .bin  (r_borrow),
    .d    (w_bit),
    .bout (w_bit_borrow)
  );

  // Result word including the bit produced this cycle; used on the final
  // step so the published diff already contains the MSB.
  always_comb begin
    w_res_next = {w_bit, r_res[WIDTH-1:1]};
    w_last     = (r_state == RUN) && (r_cnt == CNT_LAST);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (start) w_next_state = RUN;
      RUN:     if (w_last) w_next_state = DONE;
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Handshake outputs decoded from the state register only.
  always_comb begin
    ready = (r_state == IDLE);
    valid = (r_state == DONE);
  end

  // Operand capture, bit-serial shifting and result/flag publication.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_sh   <= '0;
      r_b_sh   <= '0;
      r_borrow <= 1'b0;
      r_cnt    <= '0;
      r_res    <= '0;
      r_a_msb  <= 1'b0;
      r_b_msb  <= 1'b0;
      r_diff   <= '0;
      r_bout   <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_a_sh   <= a;
            r_b_sh   <= b;
            r_borrow <= bin;
            r_cnt    <= '0;
            r_res    <= '0;
            r_a_msb  <= a[WIDTH-1];
            r_b_msb  <= b[WIDTH-1];
          end
        end
        RUN: begin
          r_a_sh   <= r_a_sh >> 1;
          r_b_sh   <= r_b_sh >> 1;
          r_borrow <= w_bit_borrow;
          r_res    <= w_res_next;
          r_cnt    <= r_cnt + CNT_W'(1);
          if (w_last) begin
            r_diff <= w_res_next;
            r_bout <= w_bit_borrow;
            // Signed overflow: operands of opposite sign and the result sign
            // differs from the minuend sign.
            r_ovf  <= (r_a_msb != r_b_msb) && (w_bit != r_a_msb);
          end
        end
        default: begin
          // DONE: nothing to update; outputs already hold the result.
        end
      endcase
    end
  end

  // Published results.
  always_comb begin
    diff = r_diff;
    bout = r_bout;
    ovf  = r_ovf;
  end

endmodule : serial_subtractor

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor (WIDTH=8): independent cycle model of the
// handshake, expected results queued at acceptance and compared at DONE.
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         ready;
  logic         valid;
  logic [W-1:0] diff;
  logic         bout;
  logic         ovf;

  int n_tests = 0;
  int n_fail  = 0;

  // {diff, bout, ovf}
  logic [W+1:0] exp_q[$];
  logic [W+1:0] held;
  int           m_cnt;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .ready (ready),
    .valid (valid),
    .diff  (diff),
    .bout  (bout),
    .ovf   (ovf)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [W+1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                         input logic mbin);
    logic [W:0]   full;
    logic [W-1:0] d;
    logic         o;
    full = {1'b0, ma} - {1'b0, mb} - {{W{1'b0}}, mbin};
    d    = full[W-1:0];
    o    = (ma[W-1] != mb[W-1]) && (d[W-1] != ma[W-1]);
    return {d, full[W], o};
  endfunction

  // Handshake model: 0 = idle, WIDTH+1 right after acceptance, 1 = DONE cycle.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt = 0;
      exp_q.delete();
    end else if (m_cnt == 0) begin
      if (start) begin
        exp_q.push_back(model(a, b, bin));
        m_cnt = W + 1;
      end
    end else begin
      m_cnt = m_cnt - 1;
    end
  end

  // Scoreboard: compare handshake and held results every cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      held = '0;
    end else begin
      chk("ready", {31'd0, ready}, {31'd0, (m_cnt == 0)});
      chk("valid", {31'd0, valid}, {31'd0, (m_cnt == 1)});
      if (m_cnt == 1) begin
        if (exp_q.size() == 0) chk("exp_avail", 32'd0, 32'd1);
        else held = exp_q.pop_front();
      end
      chk("diff", {24'd0, diff}, {24'd0, held[W+1:2]});
      chk("bout", {31'd0, bout}, {31'd0, held[1]});
      chk("ovf",  {31'd0, ovf},  {31'd0, held[0]});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_idle();
    int k;
    k = 0;
    @(negedge clk);
    while (m_cnt != 0 && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (m_cnt != 0) chk("idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic run_op(input logic [W-1:0] oa, input logic [W-1:0] ob, input logic obin);
    wait_idle();
    a     = oa;
    b     = ob;
    bin   = obin;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a     = $urandom_range(0, 255);
    b     = $urandom_range(0, 255);
    bin   = $urandom_range(0, 1);
  endtask

  task automatic run_expect(input logic [W-1:0] oa, input logic [W-1:0] ob, input logic obin,
                            input logic [W-1:0] ed, input logic eb, input logic eo);
    run_op(oa, ob, obin);
    wait_idle();
    chk("hand_diff", {24'd0, diff}, {24'd0, ed});
    chk("hand_bout", {31'd0, bout}, {31'd0, eb});
    chk("hand_ovf",  {31'd0, ovf},  {31'd0, eo});
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    bin   = 1'b0;
    #1;
    chk("rst_ready", {31'd0, ready}, 32'd1);
    chk("rst_valid", {31'd0, valid}, 32'd0);
    chk("rst_diff",  {24'd0, diff},  32'd0);
    chk("rst_bout",  {31'd0, bout},  32'd0);
    chk("rst_ovf",   {31'd0, ovf},   32'd0);
    #21 rst_n = 1'b1;

    // Directed cases with hand-derived results.
    run_expect(8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0);
    run_expect(8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0);
    run_expect(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);
    run_expect(8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1);
    run_expect(8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0);
    run_expect(8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0, 1'b0);

    // Random operations.
    for (int i = 0; i < 12; i++) begin
      run_op(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
    end

    // start held high with operands changing every cycle.
    wait_idle();
    start = 1'b1;
    for (int i = 0; i < 25; i++) begin
      a   = $urandom_range(0, 255);
      b   = $urandom_range(0, 255);
      bin = $urandom_range(0, 1);
      @(negedge clk);
    end
    start = 1'b0;
    wait_idle();

    // Reset during RUN aborts the operation.
    run_op(8'h5A, 8'h33, 1'b1);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_ready", {31'd0, ready}, 32'd1);
    chk("abort_valid", {31'd0, valid}, 32'd0);
    chk("abort_diff",  {24'd0, diff},  32'd0);
    chk("abort_bout",  {31'd0, bout},  32'd0);
    chk("abort_ovf",   {31'd0, ovf},   32'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (12) @(negedge clk);
    run_expect(8'h10, 8'h20, 1'b0, 8'hF0, 1'b1, 1'b0);

    wait_idle();
    chk("q_drained", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_serial_subtractor
